// File: rtl/text_command_decoder.sv
// text_command_decoder
//   Byte-stream command decoder feeding the video memory write port of the
//   800x600 text display. Printable bytes become cell writes at the cursor;
//   control bytes move the cursor, load the attribute word or start a
//   hardware clear that sweeps every cell at one write per clock.
//
//   Command bytes (IDLE):
//     0x00        escape: next byte is written literally as a glyph
//     0x01 x y    set cursor (values clamped to the last column/row)
//     0x02 hi lo  load attribute word {hi,lo}
//     0x03        clear screen with {attr,8'h20}
//     other       glyph written at cursor, cursor advances
//
//   Optional build macro CTRL_CHARS_EN: 0x0D returns x to 0, 0x0A moves
//   down one row (wrapping), neither writes a cell. Undefined: both are
//   plain glyphs.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   in_data/in_valid    byte from the I2C receiver
//   in_ready            byte accepted when in_valid & in_ready (low in CLEAR)
//   write               one-cycle cell write strobe
//   xtextwrite/ytextwrite  cell coordinates of the write
//   value               {attr[15:0], charindex[7:0]}
//   busy                high while the clear sweep runs
module text_command_decoder #(
    parameter int          COLS       = 100,
    parameter int          ROWS       = 37,
    parameter int          COL_W      = 7,
    parameter int          ROW_W      = 6,
    parameter logic [15:0] RESET_ATTR = 16'h0070
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             write,
    output logic [COL_W-1:0] xtextwrite,
    output logic [ROW_W-1:0] ytextwrite,
    output logic [23:0]      value,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE, ESC, GET_X, GET_Y, GET_AH, GET_AL, CLEAR
    } state_t;

    localparam logic [COL_W-1:0] X_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] Y_LAST = ROW_W'(ROWS - 1);

    state_t             state_q, state_d;
    logic [COL_W-1:0]   cur_x_q, cur_x_d;
    logic [ROW_W-1:0]   cur_y_q, cur_y_d;
    logic [COL_W-1:0]   x_lat_q, x_lat_d;
    logic [15:0]        attr_q, attr_d;
    logic [COL_W-1:0]   sweep_x_q, sweep_x_d;
    logic [ROW_W-1:0]   sweep_y_q, sweep_y_d;
    logic               clr_done_q, clr_done_d;
    logic               write_q, write_d;
    logic [COL_W-1:0]   xw_q, xw_d;
    logic [ROW_W-1:0]   yw_q, yw_d;
    logic [23:0]        value_q, value_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic               do_glyph;
    logic [COL_W-1:0]   adv_cur_x, adv_sw_x, adv_org_x;
    logic [ROW_W-1:0]   adv_cur_y, adv_sw_y, adv_org_y;

    // Row-major step with explicit end compares: last column wraps to the
    // next row, last cell wraps to (0,0).
    function automatic logic [COL_W+ROW_W-1:0] advance(
        input logic [COL_W-1:0] x,
        input logic [ROW_W-1:0] y
    );
        logic [COL_W-1:0] nx;
        logic [ROW_W-1:0] ny;
        if (x == X_LAST) begin
            nx = '0;
            ny = (y == Y_LAST) ? '0 : y + 1'b1;
        end else begin
            nx = x + 1'b1;
            ny = y;
        end
        return {ny, nx};
    endfunction

    assign {adv_cur_y, adv_cur_x} = advance(cur_x_q, cur_y_q);
    assign {adv_sw_y, adv_sw_x}   = advance(sweep_x_q, sweep_y_q);
    assign {adv_org_y, adv_org_x} = advance('0, '0);

    assign in_ready = ~busy_q;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        x_lat_d    = x_lat_q;
        attr_d     = attr_q;
        sweep_x_d  = sweep_x_q;
        sweep_y_d  = sweep_y_q;
        clr_done_d = clr_done_q;
        write_d    = 1'b0;
        xw_d       = xw_q;
        yw_d       = yw_q;
        value_d    = value_q;
        busy_d     = busy_q;
        do_glyph   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (in_data)
                        8'h00: state_d = ESC;
                        8'h01: state_d = GET_X;
                        8'h02: state_d = GET_AH;
                        8'h03: begin
                            // Cell (0,0) is written straight away so the
                            // sweep starts in the cycle after the accept.
                            state_d    = CLEAR;
                            busy_d     = 1'b1;
                            write_d    = 1'b1;
                            xw_d       = '0;
                            yw_d       = '0;
                            value_d    = {attr_q, 8'h20};
                            sweep_x_d  = adv_org_x;
                            sweep_y_d  = adv_org_y;
                            clr_done_d = (X_LAST == '0) && (Y_LAST == '0);
                        end
`ifdef CTRL_CHARS_EN
                        8'h0D: cur_x_d = '0;
                        8'h0A: cur_y_d = (cur_y_q == Y_LAST) ? '0 : cur_y_q + 1'b1;
`endif
                        default: do_glyph = 1'b1;
                    endcase
                end
            end
            ESC: begin
                if (accept) begin
                    do_glyph = 1'b1;
                    state_d  = IDLE;
                end
            end
            GET_X: begin
                if (accept) begin
                    x_lat_d = ({24'd0, in_data} >= 32'(COLS)) ? X_LAST : COL_W'(in_data);
                    state_d = GET_Y;
                end
            end
            GET_Y: begin
                if (accept) begin
                    cur_x_d = x_lat_q;
                    cur_y_d = ({24'd0, in_data} >= 32'(ROWS)) ? Y_LAST : ROW_W'(in_data);
                    state_d = IDLE;
                end
            end
            GET_AH: begin
                if (accept) begin
                    attr_d[15:8] = in_data;
                    state_d      = GET_AL;
                end
            end
            GET_AL: begin
                if (accept) begin
                    attr_d[7:0] = in_data;
                    state_d     = IDLE;
                end
            end
            CLEAR: begin
                // clr_done_q marks that the last cell went out on the
                // previous edge; busy stays high through that write cycle.
                if (clr_done_q) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    clr_done_d = 1'b0;
                    cur_x_d    = '0;
                    cur_y_d    = '0;
                end else begin
                    write_d = 1'b1;
                    xw_d    = sweep_x_q;
                    yw_d    = sweep_y_q;
                    value_d = {attr_q, 8'h20};
                    if (sweep_x_q == X_LAST && sweep_y_q == Y_LAST) begin
                        clr_done_d = 1'b1;
                    end else begin
                        sweep_x_d = adv_sw_x;
                        sweep_y_d = adv_sw_y;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_glyph) begin
            write_d = 1'b1;
            xw_d    = cur_x_q;
            yw_d    = cur_y_q;
            value_d = {attr_q, in_data};
            cur_x_d = adv_cur_x;
            cur_y_d = adv_cur_y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            x_lat_q    <= '0;
            attr_q     <= RESET_ATTR;
            sweep_x_q  <= '0;
            sweep_y_q  <= '0;
            clr_done_q <= 1'b0;
            write_q    <= 1'b0;
            xw_q       <= '0;
            yw_q       <= '0;
            value_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            x_lat_q    <= x_lat_d;
            attr_q     <= attr_d;
            sweep_x_q  <= sweep_x_d;
            sweep_y_q  <= sweep_y_d;
            clr_done_q <= clr_done_d;
            write_q    <= write_d;
            xw_q       <= xw_d;
            yw_q       <= yw_d;
            value_q    <= value_d;
            busy_q     <= busy_d;
        end
    end

    assign write      = write_q;
    assign xtextwrite = xw_q;
    assign ytextwrite = yw_q;
    assign value      = value_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_text_command_decoder.sv
module tb_text_command_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       write;
    logic [6:0] xtextwrite;
    logic [5:0] ytextwrite;
    logic [23:0] value;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

    text_command_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .write      (write),
        .xtextwrite (xtextwrite),
        .ytextwrite (ytextwrite),
        .value      (value),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present one byte for one edge; returns #1 after that edge so the
    // outputs caused by the accept are visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_cmd(input string tag, input logic [7:0] b);
        send(b);
        chk(tag, {31'd0, write}, 32'd0);
    endtask

    task automatic send_glyph(input string tag, input logic [7:0] b,
                              input int x, input int y, input logic [23:0] v);
        send(b);
        chk({tag, "_wr"}, {31'd0, write}, 32'd1);
        chk({tag, "_xy"}, {18'd0, ytextwrite, 1'b0, xtextwrite}, 32'(y * 256 + x));
        chk({tag, "_val"}, {8'd0, value}, {8'd0, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int bad;

    initial begin
        // reset state
        tick(); tick();
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_xy", {18'd0, ytextwrite, 1'b0, xtextwrite}, 32'd0);
        chk("rst_value", {8'd0, value}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // single glyph, then strobe must drop
        send_glyph("g41", 8'h41, 0, 0, 24'h007041);
        tick();
        chk("g41_pulse", {31'd0, write}, 32'd0);

        // cursor to (99,36), write, full wrap to (0,0)
        send_cmd("c01", 8'h01);
        send_cmd("cx63", 8'h63);
        send_cmd("cy24", 8'h24);
        send_glyph("g42", 8'h42, 99, 36, 24'h007042);
        send_glyph("g43", 8'h43, 0, 0, 24'h007043);

        // clamp, attribute load, escaped command byte
        send_cmd("k01", 8'h01);
        send_cmd("kxff", 8'hFF);
        send_cmd("kyff", 8'hFF);
        send_cmd("a02", 8'h02);
        send_cmd("ah12", 8'h12);
        send_cmd("al34", 8'h34);
        send_cmd("esc", 8'h00);
        send_glyph("esc02", 8'h02, 99, 36, 24'h123402);

        // clear with 0x55 held valid the whole time
        @(negedge clk);
        in_data  = 8'h03;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_data = 8'h55;
        bad = 0;
        for (int k = 0; k < 3700; k++) begin
            if (write !== 1'b1 || xtextwrite !== 7'(k % 100) || ytextwrite !== 6'(k / 100) ||
                value !== 24'h123420 || busy !== 1'b1 || in_ready !== 1'b0) begin
                if (bad == 0)
                    $display("clear cell %0d: wr=%0b x=%0d y=%0d v=%h busy=%0b rdy=%0b",
                             k, write, xtextwrite, ytextwrite, value, busy, in_ready);
                bad++;
            end
            if (k == 3699) begin
                chk("clr_last_xy", {18'd0, ytextwrite, 1'b0, xtextwrite}, 32'(36 * 256 + 99));
            end
            tick();
        end
        chk("clr_sweep_bad_cells", 32'(bad), 32'd0);
        chk("clr_end_write", {31'd0, write}, 32'd0);
        chk("clr_end_busy", {31'd0, busy}, 32'd0);
        chk("clr_end_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("g55_wr", {31'd0, write}, 32'd1);
        chk("g55_xy", {18'd0, ytextwrite, 1'b0, xtextwrite}, 32'd0);
        chk("g55_val", {8'd0, value}, 32'h123455);

        // reset in the middle of a sweep
        send(8'h03);
        for (int k = 0; k < 1000; k++) tick();
        chk("mid_xy", {18'd0, ytextwrite, 1'b0, xtextwrite}, 32'(10 * 256 + 0));
        chk("mid_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("abort_write", {31'd0, write}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        send_glyph("abort_g41", 8'h41, 0, 0, 24'h007041);

        // CR / LF handling
        send_cmd("s01", 8'h01);
        send_cmd("sx05", 8'h05);
        send_cmd("sy24", 8'h24);
`ifdef CTRL_CHARS_EN
        send_cmd("cr", 8'h0D);
        send_cmd("lf", 8'h0A);
        send_glyph("crlf_g41", 8'h41, 0, 0, 24'h007041);
`else
        send_glyph("g0d", 8'h0D, 5, 36, 24'h00700D);
        send_glyph("g0a", 8'h0A, 6, 36, 24'h00700A);
        send_glyph("g41b", 8'h41, 7, 36, 24'h007041);
`endif

        // escape of 0x03 and 0x00, x/y exactly at the limits
        send_cmd("e01", 8'h01);
        send_cmd("ex10", 8'h10);
        send_cmd("ey02", 8'h02);
        send_cmd("esc1", 8'h00);
        send_glyph("esc03", 8'h03, 16, 2, 24'h007003);
        send_cmd("esc2", 8'h00);
        send_glyph("esc00", 8'h00, 17, 2, 24'h007000);
        send_cmd("l01", 8'h01);
        send_cmd("lx64", 8'h64);
        send_cmd("ly25", 8'h25);
        send_glyph("lim", 8'h5A, 99, 36, 24'h00705A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
